// File: rtl/snitch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : snitch_pkg (with riscv_instr encodings)                          |
// | Brief   : Offload types and MUL/DIV decode for the shared muldiv unit.     |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

package riscv_instr;
  localparam logic [31:0] MUL    = 32'b0000001??????????000?????0110011;
  localparam logic [31:0] MULH   = 32'b0000001??????????001?????0110011;
  localparam logic [31:0] MULHSU = 32'b0000001??????????010?????0110011;
  localparam logic [31:0] MULHU  = 32'b0000001??????????011?????0110011;
  localparam logic [31:0] DIV    = 32'b0000001??????????100?????0110011;
  localparam logic [31:0] DIVU   = 32'b0000001??????????101?????0110011;
  localparam logic [31:0] REM    = 32'b0000001??????????110?????0110011;
  localparam logic [31:0] REMU   = 32'b0000001??????????111?????0110011;
endpackage

package snitch_pkg;
  localparam int unsigned DataWidth        = 32;
  localparam int unsigned MulDivIterations = 32;

  typedef struct packed {
    logic [31:0]          addr;
    logic [4:0]           id;
    logic [31:0]          data_op;
    logic [DataWidth-1:0] data_arga;
    logic [DataWidth-1:0] data_argb;
    logic [DataWidth-1:0] data_argc;
  } acc_req_t;

  typedef struct packed {
    logic [4:0]           id;
    logic                 error;
    logic [DataWidth-1:0] data;
  } acc_resp_t;

  typedef enum logic [3:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL
  } muldiv_op_e;

  // Only the RV32M encodings decode; the *W variants fall into ILLEGAL.
  function automatic muldiv_op_e decode_muldiv(logic [31:0] instr);
    muldiv_op_e op;
    casez (instr)
      riscv_instr::MUL:    op = MUL;
      riscv_instr::MULH:   op = MULH;
      riscv_instr::MULHSU: op = MULHSU;
      riscv_instr::MULHU:  op = MULHU;
      riscv_instr::DIV:    op = DIV;
      riscv_instr::DIVU:   op = DIVU;
      riscv_instr::REM:    op = REM;
      riscv_instr::REMU:   op = REMU;
      default:             op = ILLEGAL;
    endcase
    return op;
  endfunction
endpackage
`default_nettype wire

// File: rtl/snitch_serial_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : snitch_serial_divider                                             |
// | Brief  : Restoring radix-2 divider, one quotient bit per cycle.            |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module snitch_serial_divider
  import snitch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic        i_signed,
  input  logic        i_rem,
  output logic        o_done,
  output logic [31:0] o_result
);

  logic        r_busy;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_divisor;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_want_rem;

  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic        w_last;
  logic        w_unused;

  assign w_dvd_neg = i_signed & i_dividend[31];
  assign w_dvs_neg = i_signed & i_divisor[31];
  assign w_dvd_mag = w_dvd_neg ? (32'd0 - i_dividend) : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? (32'd0 - i_divisor) : i_divisor;

  // Quotient register doubles as the dividend shift source.
  assign w_shift     = {r_rem, r_quot[31]};
  assign w_diff      = w_shift - {1'b0, r_divisor};
  assign w_ge        = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quot_next = {r_quot[30:0], w_ge};
  assign w_last      = (r_cnt == 6'(MulDivIterations - 1));
  assign w_unused    = w_diff[32];

  // Result is taken from the final iteration combinationally, with sign fix-up.
  assign o_done   = r_busy & w_last;
  assign o_result = r_want_rem ? (r_neg_r ? (32'd0 - w_rem_next) : w_rem_next)
                               : (r_neg_q ? (32'd0 - w_quot_next) : w_quot_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_want_rem <= 1'b0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quot     <= w_dvd_mag;
      r_divisor  <= w_dvs_mag;
      r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r    <= w_dvd_neg;
      r_want_rem <= i_rem;
    end else if (r_busy) begin
      r_rem  <= w_rem_next;
      r_quot <= w_quot_next;
      if (w_last) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 6'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snitch_shared_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : snitch_shared_muldiv                                              |
// | Brief  : Shared MUL/DIV offload responder; optional SNITCH_MULDIV_EARLY_OUT_EN |
// |          enables the |dividend| < |divisor| divide shortcut.               |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+

module snitch_shared_muldiv
  import snitch_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  acc_req_t  acc_req_i,
  input  logic      acc_req_valid_i,
  output logic      acc_req_ready_o,
  output acc_resp_t acc_resp_o,
  output logic      acc_resp_valid_o,
  input  logic      acc_resp_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RESP} state_e;

  state_e      r_state;
  state_e      w_state_next;
  acc_resp_t   r_resp;

  muldiv_op_e  w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_accept;
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic signed [65:0] w_pa;
  logic signed [65:0] w_pb;
  logic signed [65:0] w_prod;
  logic [31:0] w_mul_res;
  logic        w_is_div;
  logic        w_is_rem;
  logic        w_div_signed;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_early;
  logic        w_div_fast;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_div_result;
  logic [31:0] w_imm_data;
  logic        w_unused;

  assign w_op     = decode_muldiv(acc_req_i.data_op);
  assign w_a      = acc_req_i.data_arga;
  assign w_b      = acc_req_i.data_argb;
  assign w_accept = acc_req_valid_i & acc_req_ready_o;
  assign w_unused = ^{acc_req_i.addr, acc_req_i.data_argc, w_prod[65:64]};

  // 33x33 product: the extra top bit carries the operand's sign when signed.
  assign w_a_sgn   = ((w_op == MULH) || (w_op == MULHSU)) & w_a[31];
  assign w_b_sgn   = (w_op == MULH) & w_b[31];
  assign w_pa      = 66'($signed({w_a_sgn, w_a}));
  assign w_pb      = 66'($signed({w_b_sgn, w_b}));
  assign w_prod    = w_pa * w_pb;
  assign w_mul_res = (w_op == MUL) ? w_prod[31:0] : w_prod[63:32];

  assign w_is_div     = w_op inside {DIV, DIVU, REM, REMU};
  assign w_is_rem     = w_op inside {REM, REMU};
  assign w_div_signed = w_op inside {DIV, REM};
  assign w_div_zero   = (w_b == 32'd0);
  assign w_div_ovf    = w_div_signed & (w_a == 32'h8000_0000) & (w_b == 32'hFFFF_FFFF);

`ifdef SNITCH_MULDIV_EARLY_OUT_EN
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  assign w_mag_a = (w_div_signed & w_a[31]) ? (32'd0 - w_a) : w_a;
  assign w_mag_b = (w_div_signed & w_b[31]) ? (32'd0 - w_b) : w_b;
  assign w_early = (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  assign w_div_fast  = w_div_zero | w_div_ovf | w_early;
  assign w_div_start = w_accept & w_is_div & ~w_div_fast;

  // The last branch only matters for the early-out; otherwise the divider overwrites it.
  always_comb begin
    w_imm_data = w_mul_res;
    if (w_op == ILLEGAL) begin
      w_imm_data = '0;
    end else if (w_is_div) begin
      if (w_div_zero)     w_imm_data = w_is_rem ? w_a : 32'hFFFF_FFFF;
      else if (w_div_ovf) w_imm_data = w_is_rem ? 32'd0 : 32'h8000_0000;
      else                w_imm_data = w_is_rem ? w_a : 32'd0;
    end
  end

  snitch_serial_divider u_divider (
    .clk        (clk_i),
    .rst        (rst_i),
    .i_start    (w_div_start),
    .i_dividend (w_a),
    .i_divisor  (w_b),
    .i_signed   (w_div_signed),
    .i_rem      (w_is_rem),
    .o_done     (w_div_done),
    .o_result   (w_div_result)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    acc_req_ready_o  = 1'b0;
    acc_resp_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        acc_req_ready_o = 1'b1;
        if (acc_req_valid_i) w_state_next = (w_is_div && !w_div_fast) ? S_DIV : S_RESP;
      end
      S_DIV: begin
        if (w_div_done) w_state_next = S_RESP;
      end
      S_RESP: begin
        acc_resp_valid_o = 1'b1;
        if (acc_resp_ready_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp <= '0;
    end else if (w_accept) begin
      r_resp.id    <= acc_req_i.id;
      r_resp.error <= (w_op == ILLEGAL);
      r_resp.data  <= w_imm_data;
    end else if ((r_state == S_DIV) && w_div_done) begin
      r_resp.data  <= w_div_result;
    end
  end

  assign acc_resp_o = r_resp;

endmodule
`default_nettype wire

// File: doc/snitch_shared_muldiv.md
# snitch_shared_muldiv

Shared multiply/divide responder that sits at the accelerator end of the Snitch offload interface. It accepts `acc_req_t` requests from cores whose instruction matches `shared_offload` (MUL/DIV/REM families). It executes one operation at a time: single-cycle multiply, serial radix-2 divide. It returns an `acc_resp_t` tagged with the request's destination `id`. It is instantiated once per group of cores, behind the offload arbiter.

## Interface
- No parameters; all widths come from `snitch_pkg` (`DataWidth` = 32).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `acc_req_i` in `acc_req_t`: request with fields `addr`, `id`[4:0], `data_op`[31:0], `data_arga`, `data_argb`, `data_argc`; `addr` and `data_argc` are ignored.
- `acc_req_valid_i` in 1: request valid.
- `acc_req_ready_o` out 1: request ready.
- `acc_resp_o` out `acc_resp_t`: response with fields `id`, `error`, `data`.
- `acc_resp_valid_o` out 1: response valid.
- `acc_resp_ready_i` in 1: response ready.

## Operation
- A request is accepted when `acc_req_valid_i` and `acc_req_ready_o` are both high. A response completes when `acc_resp_valid_o` and `acc_resp_ready_i` are both high.
- FSM states and behaviour:
  - IDLE: ready=1. On accept, decode `data_op`:
    - MUL, MULH, MULHSU, MULHU: compute the 33x33 signed/unsigned product, latch the selected 32 bits (low word for MUL, high word for the others), go to RESP.
    - DIV, DIVU, REM, REMU on a fast-path case: latch the result, go to RESP.
    - DIV, DIVU, REM, REMU otherwise: load the divider, go to DIV.
    - Any other op, including MULW/DIVW/DIVUW/REMW/REMUW (not legal on RV32): `error`=1, `data`=0, go to RESP.
  - DIV: ready=0. Runs 32 restoring radix-2 iterations with a 6-bit counter, then applies sign correction. On count==31, latch the result and go to RESP.
  - RESP: `acc_resp_valid_o`=1, `acc_resp_o` held stable. On handshake go to IDLE. A new request is never accepted in RESP.
- Divider sign handling:
  - Signed ops use operand magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide fast paths (baseline):
  - Divisor 0: DIV/DIVU → 0xFFFF_FFFF; REM/REMU → dividend.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; the matching REM → 0.
- `id` is captured at accept and returned unchanged in `acc_resp_o.id`.
- `error` is 0 for every legal op, including divide by zero.

## Timing
- Reset values: state=IDLE, `acc_req_ready_o`=1, `acc_resp_valid_o`=0, `acc_resp_o`=0, counter=0.
- Latency is measured from an accept at edge t to `acc_resp_valid_o` first high:
  - Multiply, fast path, illegal op: high in cycle t+1.
  - Full divide: high in cycle t+33.
- Throughput: one operation per 2 cycles at best. After the response handshake, ready returns high in the next cycle.
- Response stall: while `acc_resp_ready_i`=0, the state stays RESP and data and id are unchanged.
- Reset asserted mid-divide or in RESP: immediate return to reset values. The in-flight operation is dropped and no response is produced.
- Request inputs are sampled only at accept; later changes have no effect.

## Configuration
- `SNITCH_MULDIV_EARLY_OUT_EN` defined: an additional divide fast path is active. If the unsigned magnitude of the dividend is less than that of the divisor, then quotient=0 and remainder=dividend, with the response in cycle t+1.
- Undefined: such divides take the full 33-cycle path. Results are identical either way; only latency differs.

## Structure
- Add to `snitch_pkg`:
  - `muldiv_op_e` enum: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, ILLEGAL.
  - `decode_muldiv(logic [31:0] instr)` function, using `riscv_instr` masks.
  - `MulDivIterations` = 32.
- Sub-module `snitch_serial_divider`:
  - Inputs: start, operands, signed flag, rem flag.
  - Outputs: done and result.
  - Owns the counter and the remainder/quotient registers.
- The top level owns the FSM, the multiplier, the fast paths and the response register.

## Test plan
- MUL a=7, b=-3 (0xFFFF_FFFD), id=5 → resp t+1: data=0xFFFF_FFEB, id=5, error=0. MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE.
- DIV -7/2 → 0xFFFF_FFFD at t+33. REM -7/2 → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFF_FFFF at t+1. REM 5/0 → 5. DIV 0x8000_0000/-1 → 0x8000_0000. REM of the same operands → 0.
- `acc_resp_ready_i` held 0 for 10 cycles after a MUL → valid stays 1, data and id stable, ready=0. The next request is accepted the cycle after the handshake.
- `rst_i` pulsed at cycle 10 of a DIVU → valid=0 and ready=1 immediately. No response. A following MUL 3×4 returns 12.
- Illegal op (ADD encoding) or DIVW → error=1, data=0 at t+1. With `SNITCH_MULDIV_EARLY_OUT_EN`, DIVU 3/10 → 0 at t+1; without it, 0 at t+33.
